// File: rtl/uart_irq_arbiter_if.sv
// Bus between N_UART APB UART interrupt sources, software and the round-robin interrupt arbiter.
// The slave modport is the arbiter side; the master modport is the UART and software side.
interface uart_irq_arbiter_if #(
  parameter int unsigned N_UART = 4
);
  localparam int unsigned IDW = (N_UART > 1) ? $clog2(N_UART) : 1;

  logic [N_UART-1:0]   int_i;
  logic [4*N_UART-1:0] iir_i;
  logic [N_UART-1:0]   en_i;
  logic                ack_i;
  logic                irq_o;
  logic [IDW-1:0]      id_o;
  logic [3:0]          iir_o;
  logic                busy_o;
  logic [4*N_UART-1:0] clr_int_o;

  modport slave (
    input  int_i, iir_i, en_i, ack_i,
    output irq_o, id_o, iir_o, busy_o, clr_int_o
  );

  modport master (
    output int_i, iir_i, en_i, ack_i,
    input  irq_o, id_o, iir_o, busy_o, clr_int_o
  );
endinterface

// File: rtl/uart_irq_arbiter.sv
// Round-robin arbiter sharing one CPU interrupt among N_UART UARTs; it latches the winner's IIR
// and pulses that UART's clr_int once software acknowledges.
module uart_irq_arbiter #(
  parameter int unsigned N_UART = 4
) (
  input logic               clk_i,
  input logic               rstn_i,
  uart_irq_arbiter_if.slave bus
);
  localparam int unsigned IDW = (N_UART > 1) ? $clog2(N_UART) : 1;

  typedef enum logic [1:0] {StIdle, StServe, StClear, StHoldoff} state_e;

  state_e              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [3:0]          iir_q, iir_d;
  logic                irq_q, irq_d;
  logic                busy_q, busy_d;
  logic [4*N_UART-1:0] clr_q, clr_d;

  logic [N_UART-1:0]   pend;
  logic                found;
  logic [IDW-1:0]      win;
  logic [3:0]          win_iir;
  int unsigned         cand;

  assign pend = bus.int_i & bus.en_i;

  // Walk from ptr+1 upward with wrap; the first pending source wins.
  always_comb begin
    found   = 1'b0;
    win     = ptr_q;
    win_iir = 4'b0001;
    cand    = 0;
    for (int unsigned i = 1; i <= N_UART; i++) begin
      cand = (32'(ptr_q) + i) % N_UART;
      if (!found && pend[IDW'(cand)]) begin
        found   = 1'b1;
        win     = IDW'(cand);
        win_iir = bus.iir_i[4*cand +: 4];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    iir_d   = iir_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StServe;
          id_d    = win;
          ptr_d   = win;
          iir_d   = win_iir;
        end
      end
      StServe: begin
        // Losing the enable aborts service and outranks a same-cycle ack.
        if (!bus.en_i[id_q]) begin
          state_d = StIdle;
        end else if (bus.ack_i) begin
          state_d = StClear;
        end
      end
      StClear:   state_d = StHoldoff;
      StHoldoff: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they track the state register exactly.
  always_comb begin
    irq_d  = (state_d == StServe);
    busy_d = (state_d != StIdle);
    clr_d  = '0;
    if (state_d == StClear) begin
      for (int unsigned k = 0; k < N_UART; k++) begin
        if (IDW'(k) == id_q) begin
          clr_d[4*k +: 4] = {iir_q[3:1], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
      ptr_q   <= IDW'(N_UART - 1);
      id_q    <= '0;
      iir_q   <= 4'b0001;
      irq_q   <= 1'b0;
      busy_q  <= 1'b0;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      iir_q   <= iir_d;
      irq_q   <= irq_d;
      busy_q  <= busy_d;
      clr_q   <= clr_d;
    end
  end

  assign bus.irq_o     = irq_q;
  assign bus.id_o      = id_q;
  assign bus.iir_o     = iir_q;
  assign bus.busy_o    = busy_q;
  assign bus.clr_int_o = clr_q;
endmodule

// File: tb/tb_uart_irq_arbiter.sv
// Directed, table-driven bench for uart_irq_arbiter with N_UART = 4 plus hand-written
// sequences for asynchronous reset in SERVE and during a clear pulse.
module tb_uart_irq_arbiter;
  logic clk;
  logic rstn;

  uart_irq_arbiter_if #(.N_UART(4)) bus ();

  uart_irq_arbiter #(.N_UART(4)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]  int_v;
    logic [3:0]  en;
    logic        ack;
    logic        irq;
    logic [1:0]  id;
    logic [3:0]  iir;
    logic        busy;
    logic [15:0] clr;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic [3:0] int_v, input logic [3:0] en, input logic ack,
                     input logic irq, input logic [1:0] id, input logic [3:0] iir,
                     input logic busy, input logic [15:0] clr);
    vec_t v;
    v = '{int_v, en, ack, irq, id, iir, busy, clr};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic irq, input logic [1:0] id,
                         input logic [3:0] iir, input logic busy, input logic [15:0] clr);
    chk({tag, " irq"}, 32'(bus.irq_o), 32'(irq));
    chk({tag, " id"}, 32'(bus.id_o), 32'(id));
    chk({tag, " iir"}, 32'(bus.iir_o), 32'(iir));
    chk({tag, " busy"}, 32'(bus.busy_o), 32'(busy));
    chk({tag, " clr"}, 32'(bus.clr_int_o), 32'(clr));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Columns: int en ack | irq id iir busy clr   (iir slices: 0=4, 1=6, 2=C, 3=2)
    add(4'hB, 4'hF, 0, 1, 0, 4'h4, 1, 16'h0000);  // round robin from reset: grant 0
    add(4'hB, 4'hF, 1, 0, 0, 4'h4, 1, 16'h0004);
    add(4'hB, 4'hF, 0, 0, 0, 4'h4, 1, 16'h0000);
    add(4'hB, 4'hF, 1, 0, 0, 4'h4, 0, 16'h0000);  // ack in HOLDOFF ignored
    add(4'hB, 4'hF, 1, 1, 1, 4'h6, 1, 16'h0000);  // ack in IDLE ignored, grant 1
    add(4'hB, 4'hF, 1, 0, 1, 4'h6, 1, 16'h0060);
    add(4'hB, 4'hF, 0, 0, 1, 4'h6, 1, 16'h0000);
    add(4'hB, 4'hF, 0, 0, 1, 4'h6, 0, 16'h0000);
    add(4'hB, 4'hF, 0, 1, 3, 4'h2, 1, 16'h0000);  // grant 3
    add(4'hB, 4'hF, 1, 0, 3, 4'h2, 1, 16'h2000);
    add(4'hB, 4'hF, 0, 0, 3, 4'h2, 1, 16'h0000);
    add(4'hB, 4'hF, 0, 0, 3, 4'h2, 0, 16'h0000);
    add(4'hB, 4'hF, 0, 1, 0, 4'h4, 1, 16'h0000);  // wrap to 0
    add(4'hB, 4'hF, 1, 0, 0, 4'h4, 1, 16'h0004);
    add(4'hB, 4'hF, 0, 0, 0, 4'h4, 1, 16'h0000);
    add(4'hB, 4'hF, 0, 0, 0, 4'h4, 0, 16'h0000);
    add(4'hB, 4'hF, 0, 1, 1, 4'h6, 1, 16'h0000);  // grant 1
    add(4'hB, 4'hF, 1, 0, 1, 4'h6, 1, 16'h0060);
    add(4'h0, 4'hF, 0, 0, 1, 4'h6, 1, 16'h0000);
    add(4'h0, 4'hF, 0, 0, 1, 4'h6, 0, 16'h0000);
    add(4'h0, 4'hF, 1, 0, 1, 4'h6, 0, 16'h0000);  // stray ack in IDLE, id/iir held
    add(4'h4, 4'hF, 0, 1, 2, 4'hC, 1, 16'h0000);  // single source 2
    add(4'h4, 4'hF, 0, 1, 2, 4'hC, 1, 16'h0000);
    add(4'h4, 4'hF, 1, 0, 2, 4'hC, 1, 16'h0C00);
    add(4'h0, 4'hF, 0, 0, 2, 4'hC, 1, 16'h0000);
    add(4'h0, 4'hF, 0, 0, 2, 4'hC, 0, 16'h0000);
    add(4'h4, 4'hF, 0, 1, 2, 4'hC, 1, 16'h0000);  // self-clear case
    add(4'h0, 4'hF, 0, 1, 2, 4'hC, 1, 16'h0000);  // source drops, irq held
    add(4'h0, 4'hF, 1, 0, 2, 4'hC, 1, 16'h0C00);
    add(4'h0, 4'hF, 0, 0, 2, 4'hC, 1, 16'h0000);
    add(4'h0, 4'hF, 0, 0, 2, 4'hC, 0, 16'h0000);
    add(4'h2, 4'hF, 0, 1, 1, 4'h6, 1, 16'h0000);  // serve id 1
    add(4'hA, 4'hD, 0, 0, 1, 4'h6, 0, 16'h0000);  // mask abort
    add(4'hA, 4'hD, 0, 1, 3, 4'h2, 1, 16'h0000);  // then grant 3
    add(4'hA, 4'hD, 1, 0, 3, 4'h2, 1, 16'h2000);
    add(4'h0, 4'hF, 0, 0, 3, 4'h2, 1, 16'h0000);
    add(4'h0, 4'hF, 0, 0, 3, 4'h2, 0, 16'h0000);
    add(4'h1, 4'hF, 0, 1, 0, 4'h4, 1, 16'h0000);
    add(4'h1, 4'hE, 1, 0, 0, 4'h4, 0, 16'h0000);  // abort beats same-cycle ack
    add(4'h0, 4'hE, 0, 0, 0, 4'h4, 0, 16'h0000);

    rstn       = 1'b0;
    bus.int_i  = '0;
    bus.en_i   = '0;
    bus.ack_i  = 1'b0;
    bus.iir_i  = 16'h2C64;
    #12;
    chk_all("reset", 0, 0, 4'h1, 0, 16'h0000);
    tick();
    rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.int_i = vecs[i].int_v;
      bus.en_i  = vecs[i].en;
      bus.ack_i = vecs[i].ack;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].irq, vecs[i].id, vecs[i].iir, vecs[i].busy,
              vecs[i].clr);
    end
    bus.ack_i = 1'b0;

    // Async reset in the middle of SERVE.
    bus.int_i = 4'h4;
    bus.en_i  = 4'hF;
    tick();
    chk("pre-reset irq", 32'(bus.irq_o), 32'd1);
    chk("pre-reset id", 32'(bus.id_o), 32'd2);
    #2 rstn = 1'b0;
    #1;
    chk_all("async reset", 0, 0, 4'h1, 0, 16'h0000);
    bus.int_i = 4'h1;
    tick();
    rstn = 1'b1;
    tick();
    chk_all("first grant after reset", 1, 0, 4'h4, 1, 16'h0000);

    // Async reset cuts an in-flight clear pulse; nothing follows the release.
    bus.ack_i = 1'b1;
    tick();
    bus.ack_i = 1'b0;
    chk("clear before reset", 32'(bus.clr_int_o), 32'h0004);
    #2 rstn = 1'b0;
    #1;
    chk("clear cut by reset", 32'(bus.clr_int_o), 32'h0000);
    chk("irq in reset", 32'(bus.irq_o), 32'd0);
    bus.int_i = 4'h0;
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post-release clr %0d", i), 32'(bus.clr_int_o), 32'h0000);
      chk($sformatf("post-release busy %0d", i), 32'(bus.busy_o), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
